sample_packetiser: RTL and testbench
====================================

# sample_packetiser

Consumes the signed 16-bit sample stream from the FIR filter and emits framed byte packets toward the Ethernet MAC payload path. Samples are buffered in a FIFO. Once a full frame's worth is queued, the block emits one frame: sync word, sequence number, sample count, big-endian samples, and an XOR checksum. The output is a byte-wide valid/ready stream.

## Interface
- SAMPLES_PER_FRAME, 16: samples per frame. Range 1..255.
- FIFO_DEPTH, 64: sample FIFO depth. Power of two, at least 2*SAMPLES_PER_FRAME.
- clk  in  1  system clock (50 MHz). Single clock domain.
- rst  in  1  reset; synchronous, active-high.
- sample_in  in  16  signed filtered sample.
- sample_valid  in  1  qualifies sample_in for one cycle.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  output byte valid.
- m_tready  in  1  downstream accepts the byte.
- m_tlast  out  1  marks the last byte of a frame (the checksum byte).
- overflow  out  1  one-cycle pulse when a sample is dropped.
- drop_count  out  16  number of dropped samples; saturates at 0xFFFF.

## Operation
- Push rule: a sample is written when sample_valid=1 and the FIFO is not full. Fullness is judged on the registered count from the previous cycle; a pop in the same cycle does not free the slot.
- Push into a full FIFO: the sample is dropped, overflow pulses, and drop_count increments (saturating).
- Frame format, in order:
  - sync bytes 0xA5, 0x5A
  - SEQ (8-bit)
  - LEN = SAMPLES_PER_FRAME
  - each sample MSB then LSB
  - CSUM = XOR of SEQ, LEN and every sample byte (sync bytes excluded)
- FSM states: IDLE, SYNC_H, SYNC_L, SEQ, LEN, DATA_MSB, DATA_LSB, CSUM.
- IDLE → SYNC_H when fifo_count >= SAMPLES_PER_FRAME.
- Each non-IDLE state advances only on a handshake (m_tvalid & m_tready).
- DATA_MSB → DATA_LSB → DATA_MSB, looping until the sample counter reaches SAMPLES_PER_FRAME; then DATA_LSB → CSUM.
- CSUM → IDLE on handshake. SEQ increments at the same time, modulo 256 (255 wraps to 0).
- FIFO pop happens on the DATA_LSB handshake. The FIFO head is held unchanged during DATA_MSB/DATA_LSB.
- The checksum register clears on entry to SYNC_H and accumulates on each SEQ/LEN/DATA handshake.
- Back-to-back frames: if enough samples are queued on return to IDLE, SYNC_H follows in the next cycle.

## Timing
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0x00, overflow=0, drop_count=0, SEQ=0, FSM=IDLE, FIFO empty, checksum=0.
- fifo_count reflects a push on the cycle after sample_valid.
- The first byte (0xA5) is presented with m_tvalid=1 on the cycle after the IDLE condition is met.
- Frame length is 2*SAMPLES_PER_FRAME + 5 bytes. With m_tready held high, the frame takes exactly that many cycles.
- m_tvalid is high in every non-IDLE state.
- m_tdata and m_tlast are held stable while m_tvalid=1 and m_tready=0. m_tvalid never drops mid-frame except on reset.
- m_tlast=1 only in CSUM.
- Reset mid-frame: the next cycle is IDLE with m_tvalid=0. Queued samples are discarded and SEQ returns to 0. The truncated frame has no tlast; the downstream path discards it.
- A push and a pop in the same cycle leave the count unchanged; both take effect.

## Structure
- Package pkt_pkg holds:
  - SYNC_H=8'hA5 and SYNC_L=8'h5A
  - the FSM state enum
  - the frame overhead constant (5)
- Sub-module sample_fifo provides a synchronous FIFO with a registered count. Ports: clk, rst, wr_en, wr_data[15:0], rd_en, rd_data[15:0], count, full, empty.
- The top level contains the FSM, the byte mux, the checksum, SEQ and the drop counter.

## Test plan
- Nominal frame (SAMPLES_PER_FRAME=4, m_tready=1): push 100, 200, -150, -1000 → bytes A5 5A 00 04 00 64 00 C8 FF 6A FC 18 D9, with tlast only on D9 and 13 consecutive valid cycles.
- Backpressure: same stimulus with m_tready toggling 1,0,0,1… → identical byte sequence; tdata/tlast held stable during every stalled cycle; no duplicated or skipped bytes.
- Sequence wrap: send 257 frames → SEQ bytes run 0..255, 0; each checksum is correct.
- Overflow (FIFO_DEPTH=8, m_tready=0): push 10 samples → exactly 2 overflow pulses, drop_count=2; the first 8 samples appear in order once m_tready=1.
- Mid-frame reset: assert rst during DATA_LSB of frame 0 → m_tvalid=0 next cycle; after refill, the next frame starts A5 5A 00 with fresh data.
- Threshold: push SAMPLES_PER_FRAME-1 samples → m_tvalid stays 0; one more push → 0xA5 appears two cycles after that sample_valid.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared constants and types for the sample packetiser.
//   SYNC_H / SYNC_L : frame sync bytes, sent first and excluded from the checksum
//   FRAME_OVERHEAD  : non-sample bytes per frame (sync x2, SEQ, LEN, CSUM)
//   pkt_state_e     : byte-emission FSM states
package pkt_pkg;

    localparam logic [7:0] SYNC_H = 8'hA5;
    localparam logic [7:0] SYNC_L = 8'h5A;

    localparam int unsigned FRAME_OVERHEAD = 5;

    typedef enum logic [2:0] {
        StIdle,
        StSyncH,
        StSyncL,
        StSeq,
        StLen,
        StDataMsb,
        StDataLsb,
        StCsum
    } pkt_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous 16-bit sample FIFO with a registered occupancy count.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   wr_en     : write request; ignored while full
//   wr_data   : sample to write
//   rd_en     : pop request; ignored while empty
//   rd_data   : current head (first-word fall-through)
//   count     : registered occupancy
//   full      : count == DEPTH
//   empty     : count == 0
module sample_fifo #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    output logic [15:0]   rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;

    // Fullness comes from last cycle's count, so a same-cycle pop never frees a slot.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sample_packetiser.sv
// Buffers signed 16-bit samples and emits framed byte packets on a valid/ready stream:
//   A5 5A SEQ LEN {MSB LSB} x SAMPLES_PER_FRAME CSUM, CSUM = XOR of SEQ, LEN and sample bytes.
//   clk, rst               : clock, synchronous active-high reset
//   sample_in/sample_valid : input samples, one per qualified cycle
//   m_tdata/m_tvalid/m_tready/m_tlast : output byte stream, tlast on CSUM
//   overflow               : one-cycle pulse after a sample is dropped on a full FIFO
//   drop_count             : saturating dropped-sample count
module sample_packetiser
    import pkt_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_FRAME = 16,
    parameter int unsigned FIFO_DEPTH        = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int unsigned    CntW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] FrameThresh = CntW'(SAMPLES_PER_FRAME);
    localparam logic [7:0]     LenByte     = 8'(SAMPLES_PER_FRAME);
    localparam logic [7:0]     LastIdx     = 8'(SAMPLES_PER_FRAME - 1);

    pkt_state_e      state_q, state_d;
    logic [7:0]      smp_cnt_q, smp_cnt_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      seq_q, seq_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            overflow_q;

    logic [15:0]     fifo_rd_data;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty, fifo_rd;
    logic            hs, drop;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sample_valid),
        .wr_data (sample_in),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_tvalid   = (state_q != StIdle);
    assign hs         = m_tvalid & m_tready;
    assign drop       = sample_valid & fifo_full;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Byte mux and FSM. Everything is decoded from registered state, so tdata/tlast
    // stay put while the sink stalls.
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        csum_d    = csum_q;
        seq_d     = seq_q;
        m_tdata   = 8'h00;
        m_tlast   = 1'b0;
        fifo_rd   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fifo_count >= FrameThresh) begin
                    state_d   = StSyncH;
                    csum_d    = 8'h00;
                    smp_cnt_d = 8'h00;
                end
            end
            StSyncH: begin
                m_tdata = SYNC_H;
                if (hs) state_d = StSyncL;
            end
            StSyncL: begin
                m_tdata = SYNC_L;
                if (hs) state_d = StSeq;
            end
            StSeq: begin
                m_tdata = seq_q;
                if (hs) begin
                    csum_d  = csum_q ^ seq_q;
                    state_d = StLen;
                end
            end
            StLen: begin
                m_tdata = LenByte;
                if (hs) begin
                    csum_d  = csum_q ^ LenByte;
                    state_d = StDataMsb;
                end
            end
            StDataMsb: begin
                m_tdata = fifo_rd_data[15:8];
                if (hs) begin
                    csum_d  = csum_q ^ fifo_rd_data[15:8];
                    state_d = StDataLsb;
                end
            end
            StDataLsb: begin
                m_tdata = fifo_rd_data[7:0];
                if (hs) begin
                    csum_d  = csum_q ^ fifo_rd_data[7:0];
                    fifo_rd = ~fifo_empty;
                    if (smp_cnt_q == LastIdx) begin
                        state_d = StCsum;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 8'd1;
                        state_d   = StDataMsb;
                    end
                end
            end
            StCsum: begin
                m_tdata = csum_q;
                m_tlast = 1'b1;
                if (hs) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            smp_cnt_q  <= 8'h00;
            csum_q     <= 8'h00;
            seq_q      <= 8'h00;
            drop_cnt_q <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= drop;
        end
    end

endmodule

// File: tb/tb_sample_packetiser.sv
module tb_sample_packetiser;
    import pkt_pkg::*;

    localparam int unsigned SPF         = 4;
    localparam int unsigned DEPTH       = 8;
    localparam int unsigned FRAME_BYTES = 2 * SPF + FRAME_OVERHEAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        overflow;
    logic [15:0] drop_count;

    sample_packetiser #(
        .SAMPLES_PER_FRAME (SPF),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {tlast, tdata} per expected byte, filled as samples are pushed.
    logic [8:0]        exp_q [$];
    logic [15:0]       model_q [$];
    logic [7:0]        seq_model = 8'h00;

    bit   mon_en      = 1'b0;
    int   rdy_mode    = 0;   // 0 low, 1 high, 2 pattern 1,0,0
    int   phase       = 0;
    int   ovf_seen    = 0;
    int   frames_seen = 0;
    int   stall_cnt   = 0;
    bit   stall_prev  = 1'b0;
    bit   frame_open  = 1'b0;
    logic [8:0] prev_byte;
    logic [8:0] mon_e;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_tready = 1'b0;
            1: m_tready = 1'b1;
            default: begin
                m_tready = (phase == 0);
                phase    = (phase + 1) % 3;
            end
        endcase
    end

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_seen++;
    end

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            stall_prev = 1'b0;
            frame_open = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== prev_byte) begin
                    failures++;
                    $display("FAIL hold: got valid=%b last/data=%h want valid=1 last/data=%h",
                             m_tvalid, {m_tlast, m_tdata}, prev_byte);
                end
            end else if (frame_open) begin
                checks++;
                if (m_tvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL valid_gap: got m_tvalid=%b want 1", m_tvalid);
                end
            end
            if (m_tvalid === 1'b1 && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got last/data=%h want none",
                             {m_tlast, m_tdata});
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_tlast, m_tdata} !== mon_e) begin
                        failures++;
                        $display("FAIL byte: got last/data=%h want %h", {m_tlast, m_tdata}, mon_e);
                    end
                end
                frame_open = !m_tlast;
                if (m_tlast) frames_seen++;
            end else if (m_tvalid === 1'b1) begin
                frame_open = 1'b1;
                stall_cnt++;
            end
            stall_prev = (m_tvalid === 1'b1) && !m_tready;
            prev_byte  = {m_tlast, m_tdata};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input logic [15:0] v);
        logic [7:0] cs;
        model_q.push_back(v);
        if (model_q.size() == SPF) begin
            cs = seq_model ^ 8'(SPF);
            exp_q.push_back({1'b0, SYNC_H});
            exp_q.push_back({1'b0, SYNC_L});
            exp_q.push_back({1'b0, seq_model});
            exp_q.push_back({1'b0, 8'(SPF)});
            for (int i = 0; i < int'(SPF); i++) begin
                exp_q.push_back({1'b0, model_q[i][15:8]});
                exp_q.push_back({1'b0, model_q[i][7:0]});
                cs = cs ^ model_q[i][15:8] ^ model_q[i][7:0];
            end
            exp_q.push_back({1'b1, cs});
            seq_model = seq_model + 8'd1;
            model_q.delete();
        end
    endtask

    task automatic push_sample(input logic [15:0] v, input bit keep);
        sample_in    = v;
        sample_valid = 1'b1;
        if (keep) model_add(v);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d bytes pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_drain: got m_tvalid=%b want 0", m_tvalid);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rdy_mode = 1;
        repeat (3) tick();
        rst = 1'b0;
        checks += 5;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        if (m_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
        if (m_tdata !== 8'h00) begin failures++; $display("FAIL rst_tdata: got %h want 00", m_tdata); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        if (drop_count !== 16'h0000) begin
            failures++;
            $display("FAIL rst_drop_count: got %h want 0000", drop_count);
        end
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        logic [7:0] want [13] = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h00, 8'h64, 8'h00, 8'hC8,
                                  8'hFF, 8'h6A, 8'hFC, 8'h18, 8'hD9};
        logic [8:0] got [$];
        int n = 0;
        rdy_mode = 1;
        push_sample(16'd100, 1'b1);
        push_sample(16'd200, 1'b1);
        push_sample(-16'sd150, 1'b1);
        push_sample(-16'sd1000, 1'b1);
        @(negedge clk);
        while (m_tvalid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        while (m_tvalid === 1'b1 && got.size() < 40) begin
            got.push_back({m_tlast, m_tdata});
            @(negedge clk);
        end
        checks++;
        if (got.size() != FRAME_BYTES) begin
            failures++;
            $display("FAIL nominal_valid_cycles: got %0d want %0d", got.size(), FRAME_BYTES);
        end
        for (int i = 0; i < 13 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== {(i == 12), want[i]}) begin
                failures++;
                $display("FAIL nominal_byte%0d: got last/data=%h want %h", i, got[i],
                         {(i == 12), want[i]});
            end
        end
        wait_drain(40);
    endtask

    task automatic test_backpressure();
        int f0 = frames_seen;
        int s0 = stall_cnt;
        rdy_mode = 2;
        push_sample(16'd100, 1'b1);
        push_sample(16'd200, 1'b1);
        push_sample(-16'sd150, 1'b1);
        push_sample(-16'sd1000, 1'b1);
        wait_drain(100);
        checks += 2;
        if (frames_seen - f0 != 1) begin
            failures++;
            $display("FAIL bp_frames: got %0d want 1", frames_seen - f0);
        end
        if (stall_cnt - s0 < 1) begin
            failures++;
            $display("FAIL bp_stalls: got %0d want >0", stall_cnt - s0);
        end
        rdy_mode = 1;
    endtask

    task automatic test_threshold();
        rdy_mode = 1;
        for (int i = 0; i < int'(SPF) - 1; i++) push_sample(16'(16'h0100 + i), 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (m_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL thresh_idle: got m_tvalid=%b want 0", m_tvalid);
            end
        end
        push_sample(16'h7FFF, 1'b1);
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL thresh_plus1: got m_tvalid=%b want 0", m_tvalid);
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin
            failures++;
            $display("FAIL thresh_plus2: got valid=%b data=%h want valid=1 data=a5",
                     m_tvalid, m_tdata);
        end
        wait_drain(40);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        rdy_mode = 1;
        for (int i = 0; i < 2 * int'(SPF); i++) push_sample(16'(16'h8000 + 16'(i * 257)), 1'b1);
        @(negedge clk);
        while (!(m_tvalid === 1'b1 && m_tlast === 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: got m_tvalid=%b want 0", m_tvalid);
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_restart: got valid=%b data=%h want valid=1 data=a5",
                     m_tvalid, m_tdata);
        end
        wait_drain(60);
    endtask

    task automatic test_overflow();
        int o0 = ovf_seen;
        rdy_mode = 0;
        for (int i = 0; i < 10; i++) push_sample(16'(16'h0A00 + i), (i < 8));
        repeat (3) tick();
        checks += 3;
        if (ovf_seen - o0 != 2) begin
            failures++;
            $display("FAIL ovf_pulses: got %0d want 2", ovf_seen - o0);
        end
        if (drop_count !== 16'd2) begin
            failures++;
            $display("FAIL drop_count: got %0d want 2", drop_count);
        end
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin
            failures++;
            $display("FAIL ovf_stalled: got valid=%b data=%h want valid=1 data=a5",
                     m_tvalid, m_tdata);
        end
        rdy_mode = 1;
        wait_drain(80);
    endtask

    task automatic test_midframe_reset();
        int n = 0;
        mon_en   = 1'b0;
        rdy_mode = 1;
        push_sample(16'h1234, 1'b0);
        push_sample(16'h5678, 1'b0);
        push_sample(16'h9ABC, 1'b0);
        push_sample(16'hDEF0, 1'b0);
        @(negedge clk);
        while (m_tvalid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (m_tdata !== 8'h34 || m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_lsb: got valid=%b data=%h want valid=1 data=34", m_tvalid, m_tdata);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid: got %b want 0", m_tvalid); end
        if (m_tlast !== 1'b0) begin failures++; $display("FAIL mid_tlast: got %b want 0", m_tlast); end
        if (drop_count !== 16'h0000) begin
            failures++;
            $display("FAIL mid_drop_count: got %h want 0000", drop_count);
        end
        tick();
        exp_q.delete();
        model_q.delete();
        seq_model = 8'h00;
        mon_en    = 1'b1;
        push_sample(16'h0102, 1'b1);
        push_sample(16'h0304, 1'b1);
        push_sample(16'h0506, 1'b1);
        push_sample(16'h0708, 1'b1);
        wait_drain(40);
    endtask

    task automatic test_seq_wrap();
        int f0;
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        model_q.delete();
        seq_model = 8'h00;
        mon_en    = 1'b1;
        f0        = frames_seen;
        for (int f = 0; f < 257; f++) begin
            for (int s = 0; s < int'(SPF); s++) push_sample(16'($urandom), 1'b1);
            wait_drain(40);
        end
        checks++;
        if (frames_seen - f0 != 257) begin
            failures++;
            $display("FAIL wrap_frames: got %0d want 257", frames_seen - f0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_threshold();
        test_back_to_back();
        test_overflow();
        test_midframe_reset();
        test_seq_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
